// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, word helpers and key-schedule state type.
// Used by the cipher datapath and the key-schedule generator.
package aes_pkg;

    typedef enum logic {
        IDLE,
        EXPAND
    } key_exp_state_t;

    // Entry 0 sits in the leftmost byte
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_word.sv
// Next key-schedule word from w[i-Nk], w[i-1], phase and rcon.
// One shared SubWord instance serves both the rcon and Nk=8 mid-key steps.
module aes_key_word
    import aes_pkg::*;
#(
    parameter int Nk = 4
) (
    input  logic [31:0] w_nk,
    input  logic [31:0] w_prev,
    input  logic [2:0]  p,
    input  logic [7:0]  rcon,
    output logic [31:0] w_next
);

    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] t;

    always_comb begin
        sub_in  = (p == 3'd0) ? rot_word(w_prev) : w_prev;
        sub_out = sub_word(sub_in);
        t       = w_prev;
        if (p == 3'd0) begin
            t = sub_out ^ {rcon, 24'h0};
        end else if (Nk == 8 && p == 3'd4) begin
            t = sub_out;
        end
        w_next = w_nk ^ t;
    end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: one expanded word per cycle into a register
// file that feeds the cipher round keys directly.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [32*Nk-1:0]  key,
    output logic [31:0]       rkey [4*(Nr+1)],
    output logic              rkey_valid,
    output logic              busy
);

    localparam int NW = 4 * (Nr + 1);
    localparam int IW = $clog2(NW);

    key_exp_state_t state;
    logic [IW-1:0]  idx;
    logic [2:0]     p;
    logic [7:0]     rcon;
    logic [31:0]    w_next;

    assign key_ready = (state == IDLE);

    aes_key_word #(
        .Nk (Nk)
    ) u_word (
        .w_nk   (rkey[idx - IW'(Nk)]),
        .w_prev (rkey[idx - IW'(1)]),
        .p      (p),
        .rcon   (rcon),
        .w_next (w_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            p          <= '0;
            rcon       <= 8'h01;
            rkey_valid <= 1'b0;
            busy       <= 1'b0;
            for (int k = 0; k < NW; k++) rkey[k] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (key_valid) begin
                        for (int j = 0; j < Nk; j++)
                            rkey[j] <= key[32*j +: 32];
                        idx        <= IW'(Nk);
                        p          <= '0;
                        rcon       <= 8'h01;
                        rkey_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    rkey[idx] <= w_next;
                    idx       <= idx + IW'(1);
                    p         <= (p == 3'(Nk - 1)) ? 3'd0 : p + 3'd1;
                    if (p == 3'd0) rcon <= xtime(rcon);
                    if (idx == IW'(NW - 1)) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        rkey_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand at Nk=4/6/8 against a GF(2^8)-derived
// FIPS-197 key-schedule model.
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         kv4, kr4, rv4, b4;
    logic [127:0] k4;
    logic [31:0]  rk4 [44];
    logic         kv6, kr6, rv6, b6;
    logic [191:0] k6;
    logic [31:0]  rk6 [52];
    logic         kv8, kr8, rv8, b8;
    logic [255:0] k8;
    logic [31:0]  rk8 [60];

    aes_key_expand #(.Nk(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv4), .key_ready(kr4),
        .key(k4), .rkey(rk4), .rkey_valid(rv4), .busy(b4));
    aes_key_expand #(.Nk(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv6), .key_ready(kr6),
        .key(k6), .rkey(rk6), .rkey_valid(rv6), .busy(b6));
    aes_key_expand #(.Nk(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv8), .key_ready(kr8),
        .key(k8), .rkey(rk8), .rkey_valid(rv8), .busy(b8));

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb [256];

    localparam logic [255:0] KEY4 = {128'h0,
        32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
    localparam logic [255:0] KEY6 = {64'h0,
        32'h522c6b7b, 32'h62f8ead2, 32'h809079e5,
        32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
    localparam logic [255:0] KEY8 = {
        32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
        32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) r ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from multiplicative inverse plus affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                    ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] m_sub(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic void model(input int nk, input logic [255:0] key,
                                  output logic [31:0] w [60]);
        int total = 4 * (nk + 7);
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < total; i++) begin
            logic [31:0] t = w[i-1];
            if (i % nk == 0) begin
                logic [7:0] rc = 8'h01;
                for (int r = 1; r < i / nk; r++) rc = gmul(rc, 8'h02);
                t = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = m_sub(t);
            end
            w[i] = w[i-nk] ^ t;
        end
    endfunction

    function automatic logic [31:0] dut_word(input int nk, input int i);
        case (nk)
            4:       return rk4[i];
            6:       return rk6[i];
            default: return rk8[i];
        endcase
    endfunction

    function automatic logic dut_valid(input int nk);
        return (nk == 4) ? rv4 : (nk == 6) ? rv6 : rv8;
    endfunction

    function automatic logic dut_ready(input int nk);
        return (nk == 4) ? kr4 : (nk == 6) ? kr6 : kr8;
    endfunction

    function automatic logic dut_busy(input int nk);
        return (nk == 4) ? b4 : (nk == 6) ? b6 : b8;
    endfunction

    function automatic logic all_zero(input int nk);
        logic [31:0] acc = '0;
        for (int i = 0; i < 4 * (nk + 7); i++) acc |= dut_word(nk, i);
        return acc == '0;
    endfunction

    task automatic set_key(input int nk, input logic v,
                           input logic [255:0] key);
        case (nk)
            4: begin kv4 = v; k4 = key[127:0]; end
            6: begin kv6 = v; k6 = key[191:0]; end
            default: begin kv8 = v; k8 = key; end
        endcase
    endtask

    task automatic compare_all(input int nk, input logic [255:0] key,
                               input string tag);
        logic [31:0] mw [60];
        model(nk, key, mw);
        for (int i = 0; i < 4 * (nk + 7); i++)
            check($sformatf("%s_w%0d", tag, i), dut_word(nk, i), mw[i]);
    endtask

    task automatic wait_valid(input int nk, input string tag);
        int lat = 1;
        int ready_hi = 0;
        while (!dut_valid(nk) && lat < 200) begin
            if (dut_ready(nk)) ready_hi++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(4 * (nk + 7) - nk + 1));
        check({tag, "_ready_low"}, 32'(ready_hi), 32'd0);
        check({tag, "_busy_done"}, 32'(dut_busy(nk)), 32'd0);
    endtask

    task automatic run(input int nk, input logic [255:0] key,
                       input string tag);
        @(negedge clk);
        set_key(nk, 1'b1, key);
        @(posedge clk); #1;
        set_key(nk, 1'b0, key);
        check({tag, "_valid_drop"}, 32'(dut_valid(nk)), 32'd0);
        check({tag, "_busy"}, 32'(dut_busy(nk)), 32'd1);
        check({tag, "_w0"}, dut_word(nk, 0), key[31:0]);
        wait_valid(nk, tag);
        compare_all(nk, key, tag);
    endtask

    initial begin
        logic [255:0] ka, kb;
        build_sbox();
        rst_n = 1'b0;
        set_key(4, 1'b0, '0);
        set_key(6, 1'b0, '0);
        set_key(8, 1'b0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int nk = 4; nk <= 8; nk += 2) begin
            check($sformatf("rst%0d_zero", nk), 32'(all_zero(nk)), 32'd1);
            check($sformatf("rst%0d_valid", nk), 32'(dut_valid(nk)), 32'd0);
            check($sformatf("rst%0d_ready", nk), 32'(dut_ready(nk)), 32'd1);
            check($sformatf("rst%0d_busy", nk), 32'(dut_busy(nk)), 32'd0);
        end

        run(4, KEY4, "fips4");
        check("fips4_w4", rk4[4], 32'ha0fafe17);
        check("fips4_w43", rk4[43], 32'hb6630ca6);
        repeat (5) @(posedge clk);
        #1 check("fips4_hold", rk4[43], 32'hb6630ca6);

        run(6, KEY6, "fips6");
        check("fips6_w51", rk6[51], 32'h01002202);

        run(8, KEY8, "fips8");
        check("fips8_w12", rk8[12], 32'ha8b09c1a);
        check("fips8_w59", rk8[59], 32'h706c631e);

        for (int r = 0; r < 2; r++) begin
            for (int nk = 4; nk <= 8; nk += 2) begin
                ka = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
                run(nk, ka, $sformatf("rnd%0d_%0d", nk, r));
            end
        end

        // key_valid held through expansion with a second key
        ka = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        set_key(4, 1'b1, ka);
        @(posedge clk); #1;
        set_key(4, 1'b1, kb);
        wait_valid(4, "hold_a");
        compare_all(4, ka, "hold_a");
        @(posedge clk); #1;
        set_key(4, 1'b0, kb);
        check("b2b_valid_drop", 32'(rv4), 32'd0);
        check("b2b_w0", rk4[0], kb[31:0]);
        check("b2b_busy", 32'(b4), 32'd1);
        wait_valid(4, "hold_b");
        compare_all(4, kb, "hold_b");

        // asynchronous reset mid-expansion
        @(negedge clk);
        set_key(4, 1'b1, KEY4);
        @(posedge clk); #1;
        set_key(4, 1'b0, KEY4);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_zero", 32'(all_zero(4)), 32'd1);
        check("abort_valid", 32'(rv4), 32'd0);
        check("abort_busy", 32'(b4), 32'd0);
        check("abort_ready", 32'(kr4), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run(4, KEY4, "rerun4");
        check("rerun4_w43", rk4[43], 32'hb6630ca6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
